// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - request/response bus between a core and the data memory responder.
interface dmem_responder_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_be;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_err;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_be, resp_ready,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_be, resp_ready,
      output req_ready, resp_valid, resp_rdata, resp_err
   );
endinterface

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - single-outstanding data memory responder with fixed response latency.
module dmem_responder #(
   parameter int DEPTH_WORDS = 64,
   parameter int LATENCY     = 2
) (
   input logic              clk,
   input logic              reset,
   dmem_responder_if.slave  bus
);
   localparam int         IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t             state_q, state_d;
   logic [3:0]         cnt_q, cnt_d;
   logic               we_q, we_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [31:0]        wdata_q, wdata_d;
   logic [3:0]         be_q, be_d;
   logic               err_q, err_d;
   logic               req_ready_q, req_ready_d;
   logic               resp_valid_q, resp_valid_d;
   logic [31:0]        resp_rdata_q, resp_rdata_d;
   logic               resp_err_q, resp_err_d;

   logic [31:0]        mem [DEPTH_WORDS];

   logic               accept;
   logic               in_err;
   logic [IDX_W-1:0]   in_idx;
   logic               enter_resp;
   logic               f_we;
   logic [IDX_W-1:0]   f_idx;
   logic [31:0]        f_wdata;
   logic [3:0]         f_be;
   logic               f_err;
   logic               mem_we;

   assign accept = bus.req_valid & req_ready_q;
   assign in_idx = bus.req_addr[IDX_W+1:2];
   // Full 30-bit index compare so high addresses never alias onto the array.
   assign in_err = (bus.req_addr[1:0] != 2'b00) ||
                   ({2'b00, bus.req_addr[31:2]} >= 32'(DEPTH_WORDS));

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      we_d         = we_q;
      idx_d        = idx_q;
      wdata_d      = wdata_q;
      be_d         = be_q;
      err_d        = err_q;
      resp_rdata_d = resp_rdata_q;
      resp_err_d   = resp_err_q;
      enter_resp   = 1'b0;
      f_we         = we_q;
      f_idx        = idx_q;
      f_wdata      = wdata_q;
      f_be         = be_q;
      f_err        = err_q;

      case (state_q)
         IDLE: begin
            if (accept) begin
               we_d    = bus.req_we;
               idx_d   = in_idx;
               wdata_d = bus.req_wdata;
               be_d    = bus.req_be;
               err_d   = in_err;
               if (LATENCY > 1) begin
                  state_d = WAIT;
                  cnt_d   = CNT_INIT;
               end else begin
                  // Single-cycle latency: the memory access happens on the accept edge itself.
                  state_d    = RESP;
                  enter_resp = 1'b1;
                  f_we       = bus.req_we;
                  f_idx      = in_idx;
                  f_wdata    = bus.req_wdata;
                  f_be       = bus.req_be;
                  f_err      = in_err;
               end
            end
         end
         WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               state_d    = RESP;
               enter_resp = 1'b1;
            end
         end
         RESP: begin
            if (bus.resp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (enter_resp) begin
         resp_err_d   = f_err;
         resp_rdata_d = (!f_we && !f_err) ? mem[f_idx] : 32'd0;
      end

      req_ready_d  = (state_d == IDLE);
      resp_valid_d = (state_d == RESP);
      mem_we       = enter_resp && f_we && !f_err;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         cnt_q        <= 4'd0;
         we_q         <= 1'b0;
         idx_q        <= '0;
         wdata_q      <= 32'd0;
         be_q         <= 4'd0;
         err_q        <= 1'b0;
         req_ready_q  <= 1'b1;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= 32'd0;
         resp_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         we_q         <= we_d;
         idx_q        <= idx_d;
         wdata_q      <= wdata_d;
         be_q         <= be_d;
         err_q        <= err_d;
         req_ready_q  <= req_ready_d;
         resp_valid_q <= resp_valid_d;
         resp_rdata_q <= resp_rdata_d;
         resp_err_q   <= resp_err_d;
      end
   end

   // Memory has no reset; a reset on the commit edge drops the pending store.
   always_ff @(posedge clk) begin
      if (!reset && mem_we) begin
         for (int b = 0; b < 4; b++) begin
            if (f_be[b]) begin
               mem[f_idx][8*b +: 8] <= f_wdata[8*b +: 8];
            end
         end
      end
   end

   assign bus.req_ready  = req_ready_q;
   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_rdata = resp_rdata_q;
   assign bus.resp_err   = resp_err_q;
endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - randomized reference-model bench for dmem_responder at LATENCY 2, 1 and 15.
module tb_dmem_responder;
   localparam int DEPTH = 64;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [1:0]  sel = 2'd0;
   logic        req_valid = 1'b0;
   logic        req_we = 1'b0;
   logic [31:0] req_addr = 32'd0;
   logic [31:0] req_wdata = 32'd0;
   logic [3:0]  req_be = 4'd0;
   logic        resp_ready = 1'b0;

   logic        m_req_ready;
   logic        m_resp_valid;
   logic [31:0] m_resp_rdata;
   logic        m_resp_err;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] mdl [3][DEPTH];

   always #5 clk = ~clk;

   dmem_responder_if bus2();
   dmem_responder_if bus1();
   dmem_responder_if bus15();

   assign bus2.req_valid   = req_valid && (sel == 2'd0);
   assign bus2.resp_ready  = resp_ready && (sel == 2'd0);
   assign bus2.req_we      = req_we;
   assign bus2.req_addr    = req_addr;
   assign bus2.req_wdata   = req_wdata;
   assign bus2.req_be      = req_be;
   assign bus1.req_valid   = req_valid && (sel == 2'd1);
   assign bus1.resp_ready  = resp_ready && (sel == 2'd1);
   assign bus1.req_we      = req_we;
   assign bus1.req_addr    = req_addr;
   assign bus1.req_wdata   = req_wdata;
   assign bus1.req_be      = req_be;
   assign bus15.req_valid  = req_valid && (sel == 2'd2);
   assign bus15.resp_ready = resp_ready && (sel == 2'd2);
   assign bus15.req_we     = req_we;
   assign bus15.req_addr   = req_addr;
   assign bus15.req_wdata  = req_wdata;
   assign bus15.req_be     = req_be;

   dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(2))  u_dut2  (.clk(clk), .reset(reset), .bus(bus2.slave));
   dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1))  u_dut1  (.clk(clk), .reset(reset), .bus(bus1.slave));
   dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(15)) u_dut15 (.clk(clk), .reset(reset), .bus(bus15.slave));

   always_comb begin
      m_req_ready  = bus2.req_ready;
      m_resp_valid = bus2.resp_valid;
      m_resp_rdata = bus2.resp_rdata;
      m_resp_err   = bus2.resp_err;
      if (sel == 2'd1) begin
         m_req_ready  = bus1.req_ready;
         m_resp_valid = bus1.resp_valid;
         m_resp_rdata = bus1.resp_rdata;
         m_resp_err   = bus1.resp_err;
      end else if (sel == 2'd2) begin
         m_req_ready  = bus15.req_ready;
         m_resp_valid = bus15.resp_valid;
         m_resp_rdata = bus15.resp_rdata;
         m_resp_err   = bus15.resp_err;
      end
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h (t=%0t sel=%0d)", tag, got, exp, $time, sel);
      end
   endtask

   function automatic int lat_of(input logic [1:0] s);
      return (s == 2'd0) ? 2 : (s == 2'd1) ? 1 : 15;
   endfunction

   task automatic junk(input logic noise);
      if (noise) begin
         req_valid  = 1'($urandom_range(0, 1));
         req_we     = 1'($urandom_range(0, 1));
         req_addr   = 32'($urandom_range(0, 63)) << 2;
         req_wdata  = $urandom();
         req_be     = 4'hF;
         resp_ready = 1'($urandom_range(0, 1));
      end
   endtask

   // One full transaction on the selected responder, checked against explicit expectations.
   task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, input int bp, input logic [31:0] exp_rdata,
                         input logic exp_err, input logic noise);
      int n;
      n = 0;
      while (!m_req_ready && n < 50) begin
         @(posedge clk); #1; n++;
      end
      check_eq("req_ready_idle", m_req_ready, 1);
      req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
      resp_ready = 1'b0;
      @(posedge clk); #1;
      req_valid = 1'b0;
      n = 1;
      while (!m_resp_valid && n < 40) begin
         junk(noise);
         @(posedge clk); #1; n++;
      end
      req_valid = 1'b0; resp_ready = 1'b0;
      check_eq("latency", n, lat_of(sel));
      check_eq("resp", {m_req_ready, m_resp_err, m_resp_rdata}, {1'b0, exp_err, exp_rdata});
      for (int i = 0; i < bp; i++) begin
         junk(noise);
         resp_ready = 1'b0;
         @(posedge clk); #1;
         check_eq("hold", {m_resp_valid, m_req_ready, m_resp_err, m_resp_rdata},
                  {1'b1, 1'b0, exp_err, exp_rdata});
      end
      junk(noise);
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0; req_valid = 1'b0;
      check_eq("post_hs", {m_req_ready, m_resp_valid}, 2'b10);
   endtask

   task automatic mtxn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, input int bp, input logic noise);
      logic        err;
      logic [31:0] exp;
      int          idx;
      err = (addr % 4 != 0) || ((addr / 4) >= DEPTH);
      idx = err ? 0 : int'(addr / 4);
      exp = (!err && !we) ? mdl[sel][idx] : 32'd0;
      do_txn(we, addr, wdata, be, bp, exp, err, noise);
      if (!err && we) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b]) mdl[sel][idx][8*b +: 8] = wdata[8*b +: 8];
         end
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] a;
      int          r;
      logic [31:0] prior;

      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      for (int s = 0; s < 3; s++) begin
         sel = 2'(s); #1;
         check_eq("reset_state", {m_req_ready, m_resp_valid, m_resp_err, m_resp_rdata}, {3'b100, 32'd0});
      end
      sel = 2'd0;
      @(posedge clk); #1;
      reset = 1'b0;

      for (int s = 0; s < 3; s++) begin
         sel = 2'(s); #1;
         for (int w = 0; w < DEPTH; w++) mtxn(1'b1, 32'(w * 4), $urandom(), 4'hF, 0, 1'b0);
      end

      sel = 2'd0; #1;
      mtxn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 1'b0);
      do_txn(1'b0, 32'h10, 32'd0, 4'h0, 0, 32'hDEADBEEF, 1'b0, 1'b0);
      mtxn(1'b1, 32'h10, 32'h11223344, 4'b0101, 0, 1'b0);
      do_txn(1'b0, 32'h10, 32'd0, 4'h0, 0, 32'hDE22BE44, 1'b0, 1'b0);
      do_txn(1'b0, 32'h12, 32'd0, 4'h0, 0, 32'd0, 1'b1, 1'b0);
      do_txn(1'b1, 32'h100, 32'h55555555, 4'hF, 0, 32'd0, 1'b1, 1'b0);
      mtxn(1'b0, 32'h0, 32'd0, 4'h0, 0, 1'b0);
      mtxn(1'b1, 32'h14, 32'hA5A5A5A5, 4'b0000, 0, 1'b0);
      mtxn(1'b0, 32'h14, 32'd0, 4'h0, 5, 1'b0);

      prior = mdl[0][8];
      while (!m_req_ready) begin @(posedge clk); #1; end
      req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'hCAFEF00D; req_be = 4'hF;
      @(posedge clk); #1;
      req_valid = 1'b0;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check_eq("rst_wait", {m_req_ready, m_resp_valid}, 2'b10);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check_eq("rst_no_resp", m_resp_valid, 0);
      end
      do_txn(1'b0, 32'h20, 32'd0, 4'h0, 0, prior, 1'b0, 1'b0);

      for (int s = 1; s < 3; s++) begin
         sel = 2'(s); #1;
         mtxn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1, 1'b0);
         mtxn(1'b0, 32'h10, 32'd0, 4'h0, 0, 1'b0);
         mtxn(1'b0, 32'h0, 32'd0, 4'h0, 0, 1'b0);
      end

      for (int t = 0; t < 300; t++) begin
         r = $urandom_range(0, 9);
         sel = (r < 7) ? 2'd0 : 2'($urandom_range(1, 2));
         #1;
         r = $urandom_range(0, 9);
         if (r < 7)       a = 32'($urandom_range(0, DEPTH - 1)) << 2;
         else if (r == 7) a = (32'($urandom_range(0, DEPTH - 1)) << 2) + 32'($urandom_range(1, 3));
         else if (r == 8) a = 32'(DEPTH * 4) + (32'($urandom_range(0, 255)) << 2);
         else             a = $urandom() | 32'h8000_0000;
         mtxn(1'($urandom_range(0, 1)), a, $urandom(), 4'($urandom_range(0, 15)),
              $urandom_range(0, 3), 1'b1);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 64, number of 32-bit words stored.
REQ-002 Parameter LATENCY, default 2, cycles from request acceptance to resp_valid; legal range 1..15.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  1  core presents a request.
REQ-006 req_ready  output  1  responder can accept a request this cycle.
REQ-007 req_we  input  1  1 = store, 0 = load.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data.
REQ-010 req_be  input  4  store byte enables; bit i covers wdata[8i+7:8i].
REQ-011 resp_valid  output  1  response available.
REQ-012 resp_ready  input  1  core accepts the response.
REQ-013 resp_rdata  output  32  load data; 0 for stores and errors.
REQ-014 resp_err  output  1  request was misaligned or out of range.

Function
REQ-015 FSM states IDLE, WAIT, RESP; req_ready SHALL be 1 only in IDLE, resp_valid SHALL be 1 only in RESP.
REQ-016 Accept = req_valid & req_ready; on accept, latch we, addr, wdata, be; go to WAIT if LATENCY>1, else RESP.
REQ-017 WAIT: 4-bit counter loaded with LATENCY-1 on accept, decremented each cycle; leave WAIT for RESP when counter reaches 1, so resp_valid rises exactly LATENCY cycles after the accept edge.
REQ-018 Word index = addr[31:2]; error when addr[1:0] != 0 or index >= DEPTH_WORDS.
REQ-019 Non-error store SHALL commit to memory on the edge entering RESP, writing only bytes with be set; be=0000 commits nothing and is not an error.
REQ-020 Non-error load SHALL capture mem[index] on the edge entering RESP into a response register; it reflects any store committed earlier.
REQ-021 Error request: no memory write, resp_err=1, resp_rdata=0.
REQ-022 In RESP, resp_rdata and resp_err SHALL hold stable until resp_valid & resp_ready.
REQ-023 On response handshake go to IDLE; req_ready=1 the following cycle (no same-cycle accept; one request outstanding max).
REQ-024 req_valid while not ready is ignored; the request is not queued.
REQ-025 resp_ready while not in RESP has no effect.
REQ-026 Addresses above DEPTH_WORDS*4 SHALL NOT wrap; they error per REQ-018.

Reset
REQ-027 On reset: state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, counter=0.
REQ-028 Reset mid-transaction (WAIT or RESP) SHALL abort it; a store not yet committed is discarded, no response is produced.
REQ-029 Memory contents SHALL NOT be cleared by reset.

Verification
REQ-030 LATENCY=2: store addr 0x10, wdata 0xDEADBEEF, be 1111, resp_ready=1 -> resp_valid 2 cycles after accept, err=0, rdata=0; then load 0x10 -> rdata 0xDEADBEEF.
REQ-031 Byte enables: after REQ-030, store 0x10, wdata 0x11223344, be 0101 -> load 0x10 returns 0xDE22BE44.
REQ-032 Errors: load 0x12 -> err=1, rdata=0; store 0x100 with DEPTH_WORDS=64 -> err=1, and a later load of 0x0 is unchanged.
REQ-033 Backpressure: hold resp_ready=0 for 5 cycles in RESP -> resp_valid, rdata, err stable and req_ready=0 throughout; handshake -> req_ready=1 the next cycle.
REQ-034 Reset in WAIT of store 0x20 wdata 0xCAFEF00D -> IDLE next cycle, no resp_valid; load 0x20 returns the prior value.
REQ-035 LATENCY=1 and LATENCY=15: resp_valid rises exactly 1 and 15 cycles after accept.
